inst_fetch: RTL and testbench

Instruction fetch unit that supplies the 16-bit instruction register's load port (`inst_in` and `Wen`).
- Keeps the program counter (PC).
- Issues word reads to instruction memory over a req/ack handshake.
- Buffers fetched words in a 2-entry prefetch queue.
- Hands one instruction per control-unit `ir_load` request.
- Redirects (branch/jump) flush the queue and discard any in-flight read.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/inst_fetch.sv | 171 +++++++++++++++++
 tb/tb_inst_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the instruction fetch slice.
//   - fetch_state_t : fetch controller states (IDLE, REQ, DRAIN)
//   - fetch_entry_t : one prefetch-queue entry {pc, inst}
//   - INST_W / ADDR_W : instruction and address widths
//   - NOP_INST      : instruction shown when nothing is fetched (IR reset value)
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [INST_W-1:0] NOP_INST = 16'h4300;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // no read outstanding
        REQ   = 2'd1,  // read outstanding, response will be kept
        DRAIN = 2'd2   // read outstanding, response will be thrown away
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Small synchronous FIFO of {pc, inst} entries used as the prefetch buffer.
//   DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   push, push_pc/inst    : write one entry at the tail
//   pop                   : drop the head entry (ignored when empty)
//   flush                 : empty the queue; overrides push and pop
//   count                 : number of valid entries
//   valid                 : queue non-empty
//   head_pc / head_inst   : head entry, or 0 / NOP when empty
// -----------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH = 2,
    parameter logic [INST_W-1:0] NOP   = NOP_INST
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [ADDR_W-1:0]                 push_pc,
    input  logic [INST_W-1:0]                 push_inst,
    input  logic                              pop,
    input  logic                              flush,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              valid,
    output logic [ADDR_W-1:0]                 head_pc,
    output logic [INST_W-1:0]                 head_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;  // idle, or push+pop together
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only read once count
    // says it was written, so clearing it would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
    end

    assign count     = cnt;
    assign valid     = (cnt != '0);
    assign head_pc   = valid ? mem[rd_ptr].pc   : '0;
    assign head_inst = valid ? mem[rd_ptr].inst : NOP;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch unit feeding the IR load port. Holds the PC, reads
//   instruction words over a req/ack handshake, buffers them in a prefetch
//   queue and hands one to the IR per ir_load. A redirect flushes the queue,
//   loads a new PC and throws away any read still in flight.
//
// Parameters:
//   RESET_PC : PC after reset
//   NOP_INST : inst_out while the queue is empty
//   QDEPTH   : prefetch depth, 2 or 4
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mem_req / mem_addr    : read request, held with a stable address until ack
//   mem_ack / mem_rdata   : one-cycle response strobe with data
//   ir_load               : control unit wants the next instruction
//   inst_out / inst_pc    : head instruction and its address
//   ir_wen                : IR write enable (= ir_load & inst_valid & ~redirect)
//   inst_valid            : queue non-empty
//   redirect/redirect_pc  : branch/jump target, one-cycle pulse
//   perf_discard, perf_fetch : saturating response counters, only present
//                              when INST_FETCH_PERF_EN is defined
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = cpu_pkg::NOP_INST,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        ir_load,
    output logic [15:0] inst_out,
    output logic        ir_wen,
    output logic        inst_valid,
    output logic [15:0] inst_pc,
`ifdef INST_FETCH_PERF_EN
    output logic [15:0] perf_discard,
    output logic [15:0] perf_fetch,
`endif
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(QDEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] drain_addr;
    logic [ADDR_W-1:0] drain_addr_next;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              flush;
    logic              discard;

    // A pop is a delivered instruction; redirect cancels delivery that cycle.
    assign ir_wen = ir_load && inst_valid && !redirect;
    assign pop    = ir_wen;

    assign mem_req = (state != IDLE);
    // While draining, the PC already holds the redirect target, so the
    // abandoned read keeps its own copy of the address.
    assign mem_addr = (state == DRAIN) ? drain_addr : pc;

    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        drain_addr_next = drain_addr;
        push            = 1'b0;
        flush           = 1'b0;
        discard         = 1'b0;

        case (state)
            IDLE: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc;
                end else if (int'(count) < QDEPTH) begin
                    // Count can only shrink before the ack, so the push fits.
                    state_next = REQ;
                end
            end

            REQ: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc;
                    if (mem_ack) begin
                        discard    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        drain_addr_next = pc;
                        state_next      = DRAIN;
                    end
                end else if (mem_ack) begin
                    push    = 1'b1;
                    pc_next = pc + 16'd1;
                    // Back-to-back only when a slot is left after this push/pop.
                    if ((int'(count) + 1 - int'(pop)) < QDEPTH) state_next = REQ;
                    else                                         state_next = IDLE;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc;
                end
                if (mem_ack) begin
                    discard    = 1'b1;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            drain_addr <= drain_addr_next;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .NOP   (NOP_INST)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_pc   (pc),
        .push_inst (mem_rdata),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .valid     (inst_valid),
        .head_pc   (inst_pc),
        .head_inst (inst_out)
    );

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_discard <= '0;
            perf_fetch   <= '0;
        end else begin
            if (discard && (perf_discard != 16'hFFFF)) perf_discard <= perf_discard + 16'd1;
            if (push && (perf_fetch != 16'hFFFF))      perf_fetch   <= perf_fetch + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A memory model answers reads with
//   mem[a] = a ^ 16'hA5A5 after a programmable number of wait cycles. A
//   transaction-level model (PC, outstanding read, instruction queue) predicts
//   every output on every cycle; directed literal checks pin the model.
//   Build with INST_FETCH_PERF_EN defined to also cover the perf counters.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h4300;
    localparam int          QDEPTH   = 2;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_load;
    logic [15:0] inst_out;
    logic        ir_wen;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
`ifdef INST_FETCH_PERF_EN
    logic [15:0] perf_discard;
    logic [15:0] perf_fetch;
`endif

    int tests = 0;
    int fails = 0;

    // memory model controls
    int ack_delay = 0;
    int wait_cnt  = 0;
    bit force_ack = 1'b0;

    // reference model
    ent_t        q[$];
    ent_t        popped[$];
    logic [15:0] m_pc;
    logic [15:0] m_req_addr;
    bit          m_busy;
    bit          m_stale;
    bit          m_init = 1'b0;
    logic [15:0] m_discards;
    logic [15:0] m_fetches;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .ir_load      (ir_load),
        .inst_out     (inst_out),
        .ir_wen       (ir_wen),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
`ifdef INST_FETCH_PERF_EN
        .perf_discard (perf_discard),
        .perf_fetch   (perf_fetch),
`endif
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder, per-cycle compare, then model advance for this edge.
    always @(negedge clk) begin
        bit          exp_valid;
        bit          exp_wen;
        bit          acked;
        bit          wen;
        int          size0;
        logic [15:0] exp_inst;
        logic [15:0] exp_ipc;

        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
            wait_cnt  = 0;
        end else if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 16'hA5A5;
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end

        if (m_init) begin
            exp_valid = (q.size() > 0);
            if (exp_valid) begin
                exp_inst = q[0].inst;
                exp_ipc  = q[0].pc;
            end else begin
                exp_inst = NOP;
                exp_ipc  = 16'h0000;
            end
            exp_wen = ir_load && exp_valid && !redirect;
            check("mem_req", 16'(mem_req), 16'(m_busy));
            if (m_busy) check("mem_addr", mem_addr, m_req_addr);
            check("inst_valid", 16'(inst_valid), 16'(exp_valid));
            check("inst_out", inst_out, exp_inst);
            check("inst_pc", inst_pc, exp_ipc);
            check("ir_wen", 16'(ir_wen), 16'(exp_wen));
`ifdef INST_FETCH_PERF_EN
            check("perf_discard", perf_discard, m_discards);
            check("perf_fetch", perf_fetch, m_fetches);
`endif
            if (ir_wen === 1'b1) popped.push_back('{pc: inst_pc, inst: inst_out});
        end

        if (reset) begin
            q.delete();
            m_pc       = RESET_PC;
            m_req_addr = RESET_PC;
            m_busy     = 1'b0;
            m_stale    = 1'b0;
            m_discards = 16'h0000;
            m_fetches  = 16'h0000;
            m_init     = 1'b1;
        end else if (m_init) begin
            size0 = q.size();
            wen   = ir_load && (size0 > 0) && !redirect;
            acked = m_busy && mem_ack;
            if (wen) void'(q.pop_front());
            if (redirect) begin
                q.delete();
                if (acked) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                    if (m_discards != 16'hFFFF) m_discards = m_discards + 16'd1;
                end else if (m_busy) begin
                    m_stale = 1'b1;
                end
                m_pc = redirect_pc;
            end else if (acked) begin
                if (m_stale) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                    if (m_discards != 16'hFFFF) m_discards = m_discards + 16'd1;
                end else begin
                    q.push_back('{pc: m_pc, inst: mem_rdata});
                    if (m_fetches != 16'hFFFF) m_fetches = m_fetches + 16'd1;
                    m_pc       = m_pc + 16'd1;
                    m_busy     = (q.size() < QDEPTH);
                    m_req_addr = m_pc;
                end
            end else if (!m_busy && size0 < QDEPTH) begin
                m_busy     = 1'b1;
                m_req_addr = m_pc;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        ir_load     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;

        // ---- reset state
        tick(2);
        check("rst_mem_req", 16'(mem_req), 16'h0000);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_inst_valid", 16'(inst_valid), 16'h0000);
        check("rst_inst_out", inst_out, 16'h4300);
        check("rst_inst_pc", inst_pc, 16'h0000);
        check("rst_ir_wen", 16'(ir_wen), 16'h0000);

        // ---- fill with 1-cycle-ack memory, no loads
        reset = 1'b0;
        tick(1);
        check("fill_req0", 16'(mem_req), 16'h0001);
        check("fill_addr0", mem_addr, 16'h0000);
        tick(1);
        check("fill_addr1", mem_addr, 16'h0001);
        check("fill_latency_valid", 16'(inst_valid), 16'h0001);
        check("fill_head_inst", inst_out, 16'hA5A5);
        tick(1);
        check("full_req_low", 16'(mem_req), 16'h0000);
        check("full_head_inst", inst_out, 16'hA5A5);
        check("full_head_pc", inst_pc, 16'h0000);
        tick(2);
        check("full_stays_idle", 16'(mem_req), 16'h0000);

        // ---- continuous ir_load: in-order stream, no skips or duplicates
        popped.delete();
        ir_load = 1'b1;
        tick(12);
        ir_load   = 1'b0;
        ack_delay = 3;
        check("stream_count", 16'(popped.size()), 16'd11);
        for (int i = 0; i < popped.size() && i < 11; i++) begin
            check("stream_pc", popped[i].pc, 16'(i));
            check("stream_inst", popped[i].inst, 16'(i) ^ 16'hA5A5);
        end
        tick(12);

        // ---- redirect while a slow read is outstanding
        ir_load = 1'b1;
        tick(1);
        ir_load = 1'b0;
        tick(1);
        check("rd_in_req", 16'(mem_req), 16'h0001);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick(1);
        redirect = 1'b0;
        check("rd_drain_req", 16'(mem_req), 16'h0001);
        check("rd_flushed", 16'(inst_valid), 16'h0000);
        tick(4);
        check("rd_new_req", 16'(mem_req), 16'h0001);
        check("rd_new_addr", mem_addr, 16'h0100);
`ifdef INST_FETCH_PERF_EN
        check("rd_perf_discard", perf_discard, 16'h0001);
`endif
        tick(4);
        check("rd_valid", 16'(inst_valid), 16'h0001);
        check("rd_inst_pc", inst_pc, 16'h0100);
        check("rd_inst", inst_out, 16'hA4A5);
        ack_delay = 0;
        tick(4);

        // ---- redirect and ir_load together with a full queue
        check("rl_full", 16'(inst_valid), 16'h0001);
        ir_load     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        #1;
        check("rl_wen_blocked", 16'(ir_wen), 16'h0000);
        tick(1);
        ir_load  = 1'b0;
        redirect = 1'b0;
        check("rl_empty_next", 16'(inst_valid), 16'h0000);
        tick(1);
        check("rl_req", 16'(mem_req), 16'h0001);
        check("rl_addr", mem_addr, 16'h0200);
        tick(4);

        // ---- PC wrap at 16'hFFFF
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick(1);
        redirect = 1'b0;
        tick(1);
        check("wrap_req", 16'(mem_req), 16'h0001);
        check("wrap_addr_ffff", mem_addr, 16'hFFFF);
        tick(1);
        check("wrap_addr_0000", mem_addr, 16'h0000);
        tick(1);
        check("wrap_idle", 16'(mem_req), 16'h0000);
        check("wrap_head_pc", inst_pc, 16'hFFFF);
        check("wrap_head_inst", inst_out, 16'h5A5A);
        tick(1);

        // ---- reset mid-read, stale ack one cycle later
        ack_delay = 100;
        ir_load   = 1'b1;
        tick(1);
        ir_load = 1'b0;
        tick(1);
        check("sr_in_req", 16'(mem_req), 16'h0001);
        reset = 1'b1;
        tick(1);
        reset     = 1'b0;
        force_ack = 1'b1;
        check("sr_req_dropped", 16'(mem_req), 16'h0000);
        check("sr_empty", 16'(inst_valid), 16'h0000);
        check("sr_addr_reset", mem_addr, RESET_PC);
        tick(1);
        force_ack = 1'b0;
        ack_delay = 0;
        check("sr_stale_ignored", 16'(inst_valid), 16'h0000);
        check("sr_new_req", 16'(mem_req), 16'h0001);
        check("sr_new_addr", mem_addr, RESET_PC);
        tick(1);
        check("sr_refill_valid", 16'(inst_valid), 16'h0001);
        check("sr_refill_pc", inst_pc, 16'h0000);
        check("sr_refill_inst", inst_out, 16'hA5A5);
        tick(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
